// File: rtl/pe_dbuf_if.sv
// Handshake/bus bundle for one pe_dbuf: left/upper inputs, right/lower outputs and weight-load controls.
interface pe_dbuf_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WGT_W  = 8,
    parameter int unsigned ACC_W  = 16
);
    logic              active;
    logic [DATA_W-1:0] datain;
    logic [ACC_W-1:0]  sumin;
    logic [WGT_W-1:0]  win;
    logic              wwrite;
    logic              wswap;
    logic              sat_en;
    logic              ovf_clr;
    logic [ACC_W-1:0]  maccout;
    logic [DATA_W-1:0] dataout;
    logic              activeout;
    logic              wvalid;
    logic              wstaged;
    logic              ovf;

    modport master (
        output active, datain, sumin, win, wwrite, wswap, sat_en, ovf_clr,
        input  maccout, dataout, activeout, wvalid, wstaged, ovf
    );

    modport slave (
        input  active, datain, sumin, win, wwrite, wswap, sat_en, ovf_clr,
        output maccout, dataout, activeout, wvalid, wstaged, ovf
    );
endinterface

// File: rtl/pe_dbuf.sv
// Double-buffered MAC processing element: shadow/active weight pair, optional signed
// arithmetic, saturating or wrapping accumulate and a sticky overflow flag.
module pe_dbuf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WGT_W  = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned SIGNED = 0
) (
    input  logic     clk,
    input  logic     reset,
    pe_dbuf_if.slave bus
);
    localparam int unsigned PW        = DATA_W + WGT_W;
    localparam int unsigned EW        = ACC_W + 1;
    localparam bit          IS_SIGNED = (SIGNED != 0);

    localparam logic [1:0] S_EMPTY       = 2'd0;
    localparam logic [1:0] S_STAGED      = 2'd1;
    localparam logic [1:0] S_LIVE        = 2'd2;
    localparam logic [1:0] S_LIVE_STAGED = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WGT_W-1:0]  r_w_act;
    logic [WGT_W-1:0]  r_w_shadow;
    logic [WGT_W-1:0]  w_act_nxt;
    logic [WGT_W-1:0]  w_shadow_nxt;
    logic              r_wvalid;
    logic              r_wstaged;

    logic [ACC_W-1:0]  r_macc;
    logic [DATA_W-1:0] r_data;
    logic              r_aout;
    logic              r_ovf;

    logic              w_d_msb;
    logic              w_w_msb;
    logic              w_p_msb;
    logic              w_s_msb;
    logic [PW-1:0]     w_d_ext;
    logic [PW-1:0]     w_w_ext;
    logic [PW-1:0]     w_prod;
    logic [EW-1:0]     w_sum;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_res;

    // Weight FSM state register; status flags track the next state so they are registered with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_w_act    <= '0;
            r_w_shadow <= '0;
            r_wvalid   <= 1'b0;
            r_wstaged  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_w_act    <= w_act_nxt;
            r_w_shadow <= w_shadow_nxt;
            r_wvalid   <= (w_state_nxt == S_LIVE) || (w_state_nxt == S_LIVE_STAGED);
            r_wstaged  <= (w_state_nxt == S_STAGED) || (w_state_nxt == S_LIVE_STAGED);
        end
    end

    // Weight FSM next state; simultaneous write+swap bypasses win straight into the active weight
    always_comb begin
        w_state_nxt  = r_state;
        w_act_nxt    = r_w_act;
        w_shadow_nxt = r_w_shadow;
        if (bus.wwrite && bus.wswap) begin
            w_shadow_nxt = bus.win;
            w_act_nxt    = bus.win;
            w_state_nxt  = S_LIVE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (bus.wwrite) begin
                        w_shadow_nxt = bus.win;
                        w_state_nxt  = S_STAGED;
                    end
                end
                S_STAGED, S_LIVE_STAGED: begin
                    if (bus.wswap) begin
                        w_act_nxt   = r_w_shadow;
                        w_state_nxt = S_LIVE;
                    end else if (bus.wwrite) begin
                        w_shadow_nxt = bus.win;
                    end
                end
                default: begin
                    if (bus.wwrite) begin
                        w_shadow_nxt = bus.win;
                        w_state_nxt  = S_LIVE_STAGED;
                    end
                end
            endcase
        end
    end

    // Operands are extended to the product width, so the low PW bits are exact in either mode
    assign w_d_msb = IS_SIGNED & bus.datain[DATA_W-1];
    assign w_w_msb = IS_SIGNED & r_w_act[WGT_W-1];
    assign w_s_msb = IS_SIGNED & bus.sumin[ACC_W-1];
    assign w_d_ext = {{WGT_W{w_d_msb}}, bus.datain};
    assign w_w_ext = {{DATA_W{w_w_msb}}, r_w_act};
    assign w_prod  = w_d_ext * w_w_ext;
    assign w_p_msb = IS_SIGNED & w_prod[PW-1];
    assign w_sum   = {{(EW-PW){w_p_msb}}, w_prod} + {w_s_msb, bus.sumin};
    assign w_ovf   = IS_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];

    // Clamp or wrap; bit ACC_W carries the true sign of a signed overflow
    always_comb begin
        w_res = w_sum[ACC_W-1:0];
        if (w_ovf && bus.sat_en) begin
            if (!IS_SIGNED) begin
                w_res = '1;
            end else if (w_sum[ACC_W]) begin
                w_res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    // Output pipeline stage; an overflow on this edge wins over a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_macc <= '0;
            r_data <= '0;
            r_aout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_aout <= bus.active;
            if (bus.active) begin
                r_macc <= w_res;
                r_data <= bus.datain;
            end
            if (bus.active && w_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.maccout   = r_macc;
    assign bus.dataout   = r_data;
    assign bus.activeout = r_aout;
    assign bus.wvalid    = r_wvalid;
    assign bus.wstaged   = r_wstaged;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pe_dbuf.sv
// Scoreboarded directed bench for pe_dbuf: one unsigned and one signed instance share clk/reset.
module tb_pe_dbuf;
    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_bad;

    typedef struct {
        int          at_cyc;
        string       nm;
        logic [15:0] macc;
        logic [7:0]  data;
        logic        aout;
        logic        ovf;
        logic        wv;
        logic        ws;
    } exp_t;

    exp_t qu[$];
    exp_t qs[$];
    exp_t mon_e;

    pe_dbuf_if #(.DATA_W(8), .WGT_W(8), .ACC_W(16)) u_if ();
    pe_dbuf_if #(.DATA_W(8), .WGT_W(8), .ACC_W(16)) s_if ();

    pe_dbuf #(.DATA_W(8), .WGT_W(8), .ACC_W(16), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .bus(u_if)
    );
    pe_dbuf #(.DATA_W(8), .WGT_W(8), .ACC_W(16), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .bus(s_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input exp_t e, input logic [15:0] m, input logic [7:0] d,
                       input logic a, input logic o, input logic v, input logic w);
        n_vec++;
        if (m !== e.macc || d !== e.data || a !== e.aout || o !== e.ovf || v !== e.wv || w !== e.ws) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got macc=%h data=%h aout=%b ovf=%b wvalid=%b wstaged=%b, want macc=%h data=%h aout=%b ovf=%b wvalid=%b wstaged=%b",
                     e.nm, cyc, m, d, a, o, v, w, e.macc, e.data, e.aout, e.ovf, e.wv, e.ws);
        end
    endtask

    // Monitor: pops every expectation that has come due and compares against the DUT outputs
    always @(negedge clk) begin
        while (qu.size() != 0 && qu[0].at_cyc <= cyc) begin
            mon_e = qu.pop_front();
            chk(mon_e, u_if.maccout, u_if.dataout, u_if.activeout, u_if.ovf, u_if.wvalid, u_if.wstaged);
        end
        while (qs.size() != 0 && qs[0].at_cyc <= cyc) begin
            mon_e = qs.pop_front();
            chk(mon_e, s_if.maccout, s_if.dataout, s_if.activeout, s_if.ovf, s_if.wvalid, s_if.wstaged);
        end
    end

    task automatic clr_inputs();
        u_if.active = 0; u_if.datain = '0; u_if.sumin = '0; u_if.win = '0;
        u_if.wwrite = 0; u_if.wswap = 0; u_if.sat_en = 0; u_if.ovf_clr = 0;
        s_if.active = 0; s_if.datain = '0; s_if.sumin = '0; s_if.win = '0;
        s_if.wwrite = 0; s_if.wswap = 0; s_if.sat_en = 0; s_if.ovf_clr = 0;
    endtask

    // Drive one cycle of stimulus into the selected instance; the other idles
    task automatic drv(input bit sel, input logic act, input logic [7:0] d, input logic [15:0] s,
                       input logic [7:0] w, input logic ww, input logic wsw, input logic sat,
                       input logic clr);
        @(negedge clk);
        clr_inputs();
        if (sel) begin
            s_if.active = act; s_if.datain = d; s_if.sumin = s; s_if.win = w;
            s_if.wwrite = ww; s_if.wswap = wsw; s_if.sat_en = sat; s_if.ovf_clr = clr;
        end else begin
            u_if.active = act; u_if.datain = d; u_if.sumin = s; u_if.win = w;
            u_if.wwrite = ww; u_if.wswap = wsw; u_if.sat_en = sat; u_if.ovf_clr = clr;
        end
    endtask

    // Expected outputs after the next active edge (dly=1) or at the coming falling edge (dly=0)
    task automatic ex(input bit sel, input string nm, input logic [15:0] m, input logic [7:0] d,
                      input logic a, input logic o, input logic v, input logic w, input int dly = 1);
        exp_t e;
        e.at_cyc = cyc + dly; e.nm = nm; e.macc = m; e.data = d;
        e.aout = a; e.ovf = o; e.wv = v; e.ws = w;
        if (sel) qs.push_back(e);
        else     qu.push_back(e);
    endtask

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        clr_inputs();

        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 0);
        ex(0, "rst_u", 16'h0000, 8'h00, 0, 0, 0, 0);
        ex(1, "rst_s", 16'h0000, 8'h00, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 0);
        reset = 1'b0;

        // Unsigned load and compute
        drv(0, 0, 8'h00, 16'h0000, 8'h11, 1, 0, 0, 0); ex(0, "t1_wwrite", 16'h0000, 8'h00, 0, 0, 0, 1);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 1, 0, 0); ex(0, "t1_wswap",  16'h0000, 8'h00, 0, 0, 1, 0);
        drv(0, 1, 8'h01, 16'h0000, 8'h00, 0, 0, 0, 0); ex(0, "t1_mac",    16'h0011, 8'h01, 1, 0, 1, 0);

        // Unsigned overflow, wrap vs saturate, sticky flag
        drv(0, 0, 8'h00, 16'h0000, 8'hFF, 1, 1, 0, 0); ex(0, "t2_load",    16'h0011, 8'h01, 0, 0, 1, 0);
        drv(0, 1, 8'hFF, 16'hFF00, 8'h00, 0, 0, 0, 0); ex(0, "t2_wrap",    16'hFD01, 8'hFF, 1, 1, 1, 0);
        drv(0, 1, 8'hFF, 16'hFF00, 8'h00, 0, 0, 1, 0); ex(0, "t2_sat",     16'hFFFF, 8'hFF, 1, 1, 1, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 1); ex(0, "t2_clr",     16'hFFFF, 8'hFF, 0, 0, 1, 0);
        drv(0, 1, 8'hFF, 16'hFF00, 8'h00, 0, 0, 0, 1); ex(0, "t2_setwins", 16'hFD01, 8'hFF, 1, 1, 1, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 1); ex(0, "t2_clr2",    16'hFD01, 8'hFF, 0, 0, 1, 0);

        // Double buffering
        drv(0, 0, 8'h00, 16'h0000, 8'h02, 1, 1, 0, 0); ex(0, "t4_load2",   16'hFD01, 8'hFF, 0, 0, 1, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h05, 1, 0, 0, 0); ex(0, "t4_stage5",  16'hFD01, 8'hFF, 0, 0, 1, 1);
        drv(0, 1, 8'h01, 16'h0000, 8'h00, 0, 0, 0, 0); ex(0, "t4_oldw",    16'h0002, 8'h01, 1, 0, 1, 1);
        drv(0, 1, 8'h01, 16'h0000, 8'h00, 0, 1, 0, 0); ex(0, "t4_swapmac", 16'h0002, 8'h01, 1, 0, 1, 0);
        drv(0, 1, 8'h01, 16'h0000, 8'h00, 0, 0, 0, 0); ex(0, "t4_neww",    16'h0005, 8'h01, 1, 0, 1, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h07, 1, 1, 0, 0); ex(0, "t4_bypass",  16'h0005, 8'h01, 0, 0, 1, 0);
        drv(0, 1, 8'h03, 16'h0010, 8'h00, 0, 0, 0, 0); ex(0, "t4_mac7",    16'h0025, 8'h03, 1, 0, 1, 0);
        drv(0, 1, 8'h02, 16'h0000, 8'h09, 1, 0, 0, 0); ex(0, "t4_wrmac",   16'h000E, 8'h02, 1, 0, 1, 1);
        drv(0, 1, 8'h05, 16'h0000, 8'h00, 0, 0, 0, 0); ex(0, "t6_pre",     16'h0023, 8'h05, 1, 0, 1, 1);

        // Asynchronous reset between edges while active and staged
        drv(0, 1, 8'h06, 16'h0000, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        ex(0, "t6_async", 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 0); ex(0, "t6_hold", 16'h0000, 8'h00, 0, 0, 0, 0);
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 0);
        reset = 1'b0;
        ex(0, "t6_post", 16'h0000, 8'h00, 0, 0, 0, 0);

        // Swap in EMPTY is ignored; weight stays zero
        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 1, 0, 0); ex(0, "t5_swapempty", 16'h0000, 8'h00, 0, 0, 0, 0);
        drv(0, 1, 8'h09, 16'h0004, 8'h00, 0, 0, 0, 0); ex(0, "t5_mac",       16'h0004, 8'h09, 1, 0, 0, 0);

        // Signed instance
        drv(1, 0, 8'h00, 16'h0000, 8'hFE, 1, 1, 0, 0); ex(1, "s_loadm2",  16'h0000, 8'h00, 0, 0, 1, 0);
        drv(1, 1, 8'h03, 16'h0005, 8'h00, 0, 0, 0, 0); ex(1, "s_neg",     16'hFFFF, 8'h03, 1, 0, 1, 0);
        drv(1, 0, 8'h00, 16'h0000, 8'h01, 1, 1, 0, 0); ex(1, "s_load1",   16'hFFFF, 8'h03, 0, 0, 1, 0);
        drv(1, 1, 8'h01, 16'h7FFF, 8'h00, 0, 0, 1, 0); ex(1, "s_pos_sat", 16'h7FFF, 8'h01, 1, 1, 1, 0);
        drv(1, 1, 8'h01, 16'h7FFF, 8'h00, 0, 0, 0, 0); ex(1, "s_pos_wrap",16'h8000, 8'h01, 1, 1, 1, 0);
        drv(1, 1, 8'h80, 16'h8000, 8'h00, 0, 0, 1, 0); ex(1, "s_neg_sat", 16'h8000, 8'h80, 1, 1, 1, 0);
        drv(1, 1, 8'h80, 16'h8000, 8'h00, 0, 0, 0, 0); ex(1, "s_neg_wrap",16'h7F80, 8'h80, 1, 1, 1, 0);
        drv(1, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 1); ex(1, "s_clr",     16'h7F80, 8'h80, 0, 0, 1, 0);

        drv(0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
Parametrised, double-buffered multiply-accumulate processing element for the systolic matrix array. This is the next generation of the 8-bit/16-bit PE.
- Adds configurable widths, signed/unsigned arithmetic, saturating accumulate and a sticky overflow flag.
- Adds a shadow weight register, so the next weight tile loads while the current tile computes.
- Passes data right and partial sums down, one register stage per PE.

Parameters:
DATA_W, 8, width of activation datain/dataout
WGT_W, 8, width of weight
ACC_W, 16, width of partial sum; must be >= DATA_W+WGT_W
SIGNED, 0, 1 = two's-complement operands and sum; 0 = unsigned

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
active  input  1  perform MAC this cycle
datain  input  DATA_W  activation from left neighbour
sumin  input  ACC_W  partial sum from upper neighbour
win  input  WGT_W  weight to load into shadow register
wwrite  input  1  write win into shadow register
wswap  input  1  promote shadow weight to active weight
sat_en  input  1  1 = saturate on overflow; 0 = wrap
ovf_clr  input  1  clear sticky overflow flag
maccout  output  ACC_W  registered sumin + datain*w_act
dataout  output  DATA_W  registered datain to right neighbour
activeout  output  1  registered active to right neighbour
wvalid  output  1  active weight has been loaded since reset
wstaged  output  1  shadow holds a weight not yet swapped in
ovf  output  1  sticky overflow flag

Behaviour:
- Reset (async, any time, including mid-operation): maccout, dataout, activeout, ovf, w_act and w_shadow = 0; weight FSM = EMPTY. All outputs 0 while reset is high.
- MAC, 1-cycle latency. On the edge where active=1:
  - maccout <= sumin + datain*w_act
  - dataout <= datain
  - activeout <= 1
- On the edge where active=0: maccout and dataout hold; activeout <= 0; ovf holds unless cleared.
- Arithmetic:
  - The product is DATA_W+WGT_W bits. It is extended to ACC_W+1 bits: sign-extended if SIGNED, else zero-extended.
  - sumin is extended the same way, and the sum is formed in ACC_W+1 bits.
  - Unsigned overflow: bit ACC_W is set.
  - Signed overflow: bit ACC_W differs from bit ACC_W-1.
  - sat_en=1: clamp to the max on positive overflow and to the min on negative overflow. Unsigned: max=all ones; an unsigned overflow is always positive. Signed: max=0111..1, min=1000..0.
  - sat_en=0: keep the low ACC_W bits.
- ovf:
  - Set on any active cycle that overflows, regardless of sat_en.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Weight FSM states: EMPTY, STAGED, LIVE, LIVE_STAGED.
  - EMPTY: wwrite -> STAGED; wswap alone is ignored (w_act unchanged).
  - STAGED: wswap -> LIVE (w_act <= w_shadow); wwrite alone overwrites the shadow and stays in STAGED.
  - LIVE: wwrite -> LIVE_STAGED.
  - LIVE_STAGED: wswap -> LIVE; wwrite alone overwrites the shadow.
  - wwrite and wswap in the same cycle, from any state: w_shadow <= win, w_act <= win (bypass), next state LIVE.
  - wvalid = LIVE or LIVE_STAGED. wstaged = STAGED or LIVE_STAGED. Both are registered with the FSM state.
- wswap with active=1 in the same cycle: that MAC uses the old w_act; the new weight applies from the next cycle.
- wwrite never affects the MAC of the current cycle.

Test Plan:
1. Unsigned load/compute. wwrite with win=8'h11, then wswap, then active with datain=8'h01, sumin=0 -> next cycle maccout=16'h0011, dataout=8'h01, activeout=1, wvalid=1, wstaged=0.
2. Unsigned overflow. w_act=8'hFF, datain=8'hFF, sumin=16'hFF00 (raw 17'h1FD01):
   - sat_en=0 -> maccout=16'hFD01, ovf=1.
   - sat_en=1 -> maccout=16'hFFFF, ovf=1.
   - Then ovf_clr alone -> ovf=0.
   - Then ovf_clr together with an overflowing MAC -> ovf stays 1.
3. SIGNED=1:
   - w_act=8'hFE (-2), datain=8'h03, sumin=16'h0005 -> maccout=16'hFFFF, ovf=0.
   - w_act=1, datain=1, sumin=16'h7FFF: sat_en=1 -> 16'h7FFF; sat_en=0 -> 16'h8000; ovf=1 in both cases.
4. Double buffer:
   - With w_act=8'h02 live, wwrite 8'h05 -> wstaged=1, and the next MAC (datain=1, sumin=0) still gives 2.
   - wswap together with active (datain=1, sumin=0) -> that cycle gives 2, the following cycle gives 5.
   - wwrite+wswap together with win=8'h07 -> w_act=7, FSM LIVE.
5. wswap in EMPTY after reset -> wvalid stays 0; an active cycle with datain=8'h09, sumin=16'h0004 -> maccout=16'h0004.
6. Reset mid-operation. Assert reset asynchronously (between edges) while active=1 and wstaged=1 -> all outputs 0 immediately, weights 0. After deassert, wvalid=0 and wstaged=0.
